// File: rtl/vdma_pkg.sv
// vdma_pkg: shared types and reset constants for the VDMA triple-buffer frame scheduler.
package vdma_pkg;

  typedef logic [1:0] buf_idx_t;

  typedef enum logic [0:0] {
    W_IDLE   = 1'b0,
    W_ACTIVE = 1'b1
  } wr_state_t;

  localparam int unsigned NUM_BUF = 3;

  // Reset ownership: reader on buffer 0, writer on buffer 1, buffer 2 parked as spare.
  localparam buf_idx_t RD_IDX_RST    = 2'd0;
  localparam buf_idx_t WR_IDX_RST    = 2'd1;
  localparam buf_idx_t SPARE_IDX_RST = 2'd2;

endpackage

// File: rtl/vdma_sched_stats.sv
// vdma_sched_stats: saturating committed-frame and dropped-frame counters.
module vdma_sched_stats #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc_frames,
  input  logic                 i_inc_drops,
  output logic [CNT_WIDTH-1:0] o_frames,
  output logic [CNT_WIDTH-1:0] o_drops
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_frames;
  logic [CNT_WIDTH-1:0] r_drops;

  // Count committed frames and overwritten frames, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frames <= '0;
      r_drops  <= '0;
    end else begin
      if (i_inc_frames && (r_frames != CNT_MAX)) begin
        r_frames <= r_frames + CNT_ONE;
      end else begin
        r_frames <= r_frames;
      end
      if (i_inc_drops && (r_drops != CNT_MAX)) begin
        r_drops <= r_drops + CNT_ONE;
      end else begin
        r_drops <= r_drops;
      end
    end
  end

  assign o_frames = r_frames;
  assign o_drops  = r_drops;

endmodule

// File: rtl/vdma_frame_sched.sv
// vdma_frame_sched: triple-buffer scheduler between one frame writer and one display reader.
// The reader always gets the freshest completed frame at vsync; the writer never blocks.
// Build option: define VDMA_SCHED_STATS_EN to build the statistics counters; otherwise
// stat_wr_frames/stat_drops are tied to zero.
module vdma_frame_sched
  import vdma_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h1000_0000),
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = ADDR_WIDTH'(32'h0020_0000),
  parameter int unsigned           CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr_frame_start,
  input  logic                  wr_frame_done,
  input  logic                  rd_vsync,
  output logic                  wr_grant,
  output buf_idx_t              wr_buf_idx,
  output logic [ADDR_WIDTH-1:0] wr_base_addr,
  output buf_idx_t              rd_buf_idx,
  output logic [ADDR_WIDTH-1:0] rd_base_addr,
  output logic                  rd_new_frame,
  output logic                  err_protocol,
  output logic [CNT_WIDTH-1:0]  stat_wr_frames,
  output logic [CNT_WIDTH-1:0]  stat_drops
);

  // Base address of a buffer; wraps modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] buf_addr(input buf_idx_t idx);
    return BASE_ADDR + (ADDR_WIDTH'(idx) * FRAME_STRIDE);
  endfunction

  wr_state_t             r_state;
  wr_state_t             w_state_nxt;
  logic                  w_grant_set;
  logic                  w_commit;
  logic                  w_err_set;

  buf_idx_t              r_rd_idx;
  buf_idx_t              r_wr_idx;
  buf_idx_t              r_spare_idx;
  logic                  r_spare_valid;
  logic                  r_wr_grant;
  logic                  r_rd_new_frame;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;

  // Writer FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= W_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Writer FSM next state, grant request, commit and protocol-error detection.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_set = 1'b0;
    w_commit    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      W_IDLE: begin
        if (wr_frame_done) begin
          w_err_set = 1'b1;
        end else begin
          w_err_set = 1'b0;
        end
        if (wr_frame_start && enable) begin
          w_state_nxt = W_ACTIVE;
          w_grant_set = 1'b1;
        end else begin
          w_state_nxt = W_IDLE;
        end
      end
      W_ACTIVE: begin
        // A start during an active frame is always an error, even alongside done.
        if (wr_frame_start) begin
          w_err_set = 1'b1;
        end else begin
          w_err_set = 1'b0;
        end
        if (wr_frame_done) begin
          w_commit    = 1'b1;
          w_state_nxt = W_IDLE;
        end else begin
          w_state_nxt = W_ACTIVE;
        end
      end
      default: begin
        w_state_nxt = W_IDLE;
      end
    endcase
  end

  // Buffer ownership rotation, output pulses and sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_idx       <= RD_IDX_RST;
      r_wr_idx       <= WR_IDX_RST;
      r_spare_idx    <= SPARE_IDX_RST;
      r_spare_valid  <= 1'b0;
      r_wr_grant     <= 1'b0;
      r_rd_new_frame <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_wr_grant     <= w_grant_set;
      r_rd_new_frame <= 1'b0;
      r_err          <= r_err | w_err_set;
      if (w_commit && rd_vsync) begin
        // Fresh frame goes straight to the reader; any pending spare is dropped.
        r_rd_idx       <= r_wr_idx;
        r_wr_idx       <= r_rd_idx;
        r_spare_valid  <= 1'b0;
        r_rd_new_frame <= 1'b1;
      end else if (w_commit) begin
        r_spare_idx   <= r_wr_idx;
        r_wr_idx      <= r_spare_idx;
        r_spare_valid <= 1'b1;
      end else if (rd_vsync && r_spare_valid) begin
        r_rd_idx       <= r_spare_idx;
        r_spare_idx    <= r_rd_idx;
        r_spare_valid  <= 1'b0;
        r_rd_new_frame <= 1'b1;
      end else begin
        r_spare_valid <= r_spare_valid;
      end
    end
  end

  // Base addresses follow the indices one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr <= buf_addr(WR_IDX_RST);
      r_rd_addr <= buf_addr(RD_IDX_RST);
    end else begin
      r_wr_addr <= buf_addr(r_wr_idx);
      r_rd_addr <= buf_addr(r_rd_idx);
    end
  end

  assign wr_grant     = r_wr_grant;
  assign wr_buf_idx   = r_wr_idx;
  assign wr_base_addr = r_wr_addr;
  assign rd_buf_idx   = r_rd_idx;
  assign rd_base_addr = r_rd_addr;
  assign rd_new_frame = r_rd_new_frame;
  assign err_protocol = r_err;

`ifdef VDMA_SCHED_STATS_EN
  logic w_drop;
  assign w_drop = w_commit & r_spare_valid;

  vdma_sched_stats #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stats (
    .clk          (clk),
    .rst          (rst),
    .i_inc_frames (w_commit),
    .i_inc_drops  (w_drop),
    .o_frames     (stat_wr_frames),
    .o_drops      (stat_drops)
  );
`else
  assign stat_wr_frames = '0;
  assign stat_drops     = '0;
`endif

endmodule

// File: tb/tb_vdma_frame_sched.sv
// tb_vdma_frame_sched: scoreboard bench for the triple-buffer frame scheduler.
module tb_vdma_frame_sched;

`ifdef VDMA_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic        grant;
    logic        nf;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        err;
    logic [31:0] rd_a;
    logic [31:0] wr_a;
    logic [15:0] swf;
    logic [15:0] sdr;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr_frame_start = 1'b0;
  logic        wr_frame_done = 1'b0;
  logic        rd_vsync = 1'b0;
  logic        wr_grant;
  logic [1:0]  wr_buf_idx;
  logic [31:0] wr_base_addr;
  logic [1:0]  rd_buf_idx;
  logic [31:0] rd_base_addr;
  logic        rd_new_frame;
  logic        err_protocol;
  logic [15:0] stat_wr_frames;
  logic [15:0] stat_drops;

  int errors = 0;
  int checks = 0;
  out_t sb[$];

  // reference model state
  logic       m_act;
  logic [1:0] m_rd, m_wr, m_sp;
  logic       m_v, m_err;
  logic [15:0] m_wf, m_dr;

  vdma_frame_sched dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .wr_frame_start (wr_frame_start),
    .wr_frame_done  (wr_frame_done),
    .rd_vsync       (rd_vsync),
    .wr_grant       (wr_grant),
    .wr_buf_idx     (wr_buf_idx),
    .wr_base_addr   (wr_base_addr),
    .rd_buf_idx     (rd_buf_idx),
    .rd_base_addr   (rd_base_addr),
    .rd_new_frame   (rd_new_frame),
    .err_protocol   (err_protocol),
    .stat_wr_frames (stat_wr_frames),
    .stat_drops     (stat_drops)
  );

  always #5 clk = ~clk;

  // Reader and writer must never own the same buffer.
  always @(negedge clk) begin
    checks++;
    if (rd_buf_idx === wr_buf_idx) begin
      errors++;
      $display("FAIL idx_distinct t=%0t: rd_buf_idx=%0d wr_buf_idx=%0d must differ", $time, rd_buf_idx, wr_buf_idx);
    end
  end

  function automatic logic [31:0] tb_addr(input logic [1:0] idx);
    logic [31:0] i32;
    i32 = {30'd0, idx};
    return 32'h1000_0000 + i32 * 32'h0020_0000;
  endfunction

  function automatic out_t sample();
    return {wr_grant, rd_new_frame, rd_buf_idx, wr_buf_idx, err_protocol,
            rd_base_addr, wr_base_addr, stat_wr_frames, stat_drops};
  endfunction

  // Drive one cycle of stimulus, push the model's expected outputs, advance past the edge.
  task automatic step(input logic en, input logic st, input logic dn, input logic vs, input logic r);
    out_t e;
    logic cm;
    logic [1:0] t;
    enable = en; wr_frame_start = st; wr_frame_done = dn; rd_vsync = vs; rst = r;
    e = '0;
    if (r) begin
      m_act = 1'b0; m_rd = 2'd0; m_wr = 2'd1; m_sp = 2'd2; m_v = 1'b0; m_err = 1'b0;
      m_wf = 16'd0; m_dr = 16'd0;
      e.rd_a = tb_addr(2'd0);
      e.wr_a = tb_addr(2'd1);
    end else begin
      e.rd_a = tb_addr(m_rd);
      e.wr_a = tb_addr(m_wr);
      cm = m_act && dn;
      e.grant = !m_act && st && en;
      if ((m_act && st) || (!m_act && dn)) m_err = 1'b1;
      if (cm && STATS) begin
        if (m_wf != 16'hFFFF) m_wf = m_wf + 16'd1;
        if (m_v && (m_dr != 16'hFFFF)) m_dr = m_dr + 16'd1;
      end
      if (cm && vs) begin
        t = m_rd; m_rd = m_wr; m_wr = t; m_v = 1'b0; e.nf = 1'b1;
      end else if (cm) begin
        t = m_sp; m_sp = m_wr; m_wr = t; m_v = 1'b1;
      end else if (vs && m_v) begin
        t = m_rd; m_rd = m_sp; m_sp = t; m_v = 1'b0; e.nf = 1'b1;
      end
      if (cm) m_act = 1'b0;
      else if (e.grant) m_act = 1'b1;
    end
    e.rd = m_rd; e.wr = m_wr; e.err = m_err; e.swf = m_wf; e.sdr = m_dr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    wr_frame_start = 1'b0; wr_frame_done = 1'b0; rd_vsync = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    out_t e, o;
    logic [4:0] p [3] = '{5'b00001, 5'b00001, 5'b00000};  // {rst,en,st,dn,vs} after reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_state: got %h want %h", o, e); end
    checks++;
    if (rd_base_addr !== 32'h1000_0000 || wr_base_addr !== 32'h1020_0000) begin
      errors++; $display("FAIL reset_addr: got rd=%h wr=%h want 10000000/10200000", rd_base_addr, wr_base_addr);
    end
    for (int i = 0; i < 3; i++) begin
      step(p[i][3], p[i][2], p[i][1], p[i][0], p[i][4]);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_vsync step %0d: got %h want %h", i, o, e); end
    end
    checks++;
    if (rd_buf_idx !== 2'd0 || rd_base_addr !== 32'h1000_0000 || rd_new_frame !== 1'b0) begin
      errors++; $display("FAIL reset_repeat: got rd=%0d addr=%h nf=%b want 0/10000000/0", rd_buf_idx, rd_base_addr, rd_new_frame);
    end
  endtask

  task automatic test_grant_commit();
    out_t e, o;
    logic [4:0] p [4] = '{5'b11000, 5'b01100, 5'b01010, 5'b01001};
    for (int i = 0; i < 4; i++) begin
      step(p[i][3], p[i][2], p[i][1], p[i][0], p[i][4]);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL grant_commit step %0d: got %h want %h", i, o, e); end
      if (i == 1) begin
        checks++;
        if (wr_grant !== 1'b1 || wr_buf_idx !== 2'd1 || wr_base_addr !== 32'h1020_0000) begin
          errors++; $display("FAIL grant_pulse: got g=%b idx=%0d addr=%h want 1/1/10200000", wr_grant, wr_buf_idx, wr_base_addr);
        end
      end
    end
    checks++;
    if (rd_buf_idx !== 2'd1 || rd_new_frame !== 1'b1 || wr_buf_idx !== 2'd2) begin
      errors++; $display("FAIL vsync_swap: got rd=%0d nf=%b wr=%0d want 1/1/2", rd_buf_idx, rd_new_frame, wr_buf_idx);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL grant_commit addr_follow: got %h want %h", o, e); end
  endtask

  task automatic test_drop();
    out_t e, o;
    logic [4:0] p [7] = '{5'b10000, 5'b01100, 5'b01010, 5'b01100, 5'b01010, 5'b01000, 5'b01001};
    for (int i = 0; i < 7; i++) begin
      step(p[i][3], p[i][2], p[i][1], p[i][0], p[i][4]);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL drop step %0d: got %h want %h", i, o, e); end
    end
    checks++;
    if (rd_buf_idx !== 2'd2 || rd_new_frame !== 1'b1 || stat_drops !== (STATS ? 16'd1 : 16'd0)
        || stat_wr_frames !== (STATS ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL drop_result: got rd=%0d nf=%b drops=%0d frames=%0d", rd_buf_idx, rd_new_frame, stat_drops, stat_wr_frames);
    end
  endtask

  task automatic test_back_to_back();
    out_t e, o;
    logic [4:0] p [5] = '{5'b10000, 5'b01100, 5'b01011, 5'b01100, 5'b01011};
    for (int i = 0; i < 5; i++) begin
      step(p[i][3], p[i][2], p[i][1], p[i][0], p[i][4]);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back step %0d: got %h want %h", i, o, e); end
      if (i == 2) begin
        checks++;
        if (rd_buf_idx !== 2'd1 || wr_buf_idx !== 2'd0 || rd_new_frame !== 1'b1) begin
          errors++; $display("FAIL done_vsync: got rd=%0d wr=%0d nf=%b want 1/0/1", rd_buf_idx, wr_buf_idx, rd_new_frame);
        end
      end
    end
  endtask

  task automatic test_protocol_err();
    out_t e, o;
    logic [4:0] p [7] = '{5'b10000, 5'b00100, 5'b00010, 5'b01100, 5'b01100, 5'b00110, 5'b00000};
    for (int i = 0; i < 7; i++) begin
      step(p[i][3], p[i][2], p[i][1], p[i][0], p[i][4]);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL protocol step %0d: got %h want %h", i, o, e); end
      if (i == 2) begin
        checks++;
        if (err_protocol !== 1'b1 || rd_buf_idx !== 2'd0 || wr_buf_idx !== 2'd1) begin
          errors++; $display("FAIL done_idle: got err=%b rd=%0d wr=%0d want 1/0/1", err_protocol, rd_buf_idx, wr_buf_idx);
        end
      end
    end
    checks++;
    if (err_protocol !== 1'b1 || wr_buf_idx !== 2'd2) begin
      errors++; $display("FAIL err_sticky: got err=%b wr=%0d want 1/2", err_protocol, wr_buf_idx);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || err_protocol !== 1'b0) begin errors++; $display("FAIL err_cleared: got %h want %h", o, e); end
  endtask

  task automatic test_mid_reset();
    out_t e, o;
    logic [4:0] p [5] = '{5'b01100, 5'b01000, 5'b10000, 5'b01000, 5'b01010};
    for (int i = 0; i < 5; i++) begin
      step(p[i][3], p[i][2], p[i][1], p[i][0], p[i][4]);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL mid_reset step %0d: got %h want %h", i, o, e); end
      if (i == 2) begin
        checks++;
        if (rd_buf_idx !== 2'd0 || wr_buf_idx !== 2'd1 || wr_grant !== 1'b0 || err_protocol !== 1'b0) begin
          errors++; $display("FAIL reset_abort: got rd=%0d wr=%0d g=%b err=%b want 0/1/0/0", rd_buf_idx, wr_buf_idx, wr_grant, err_protocol);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_grant_commit();
    test_drop();
    test_back_to_back();
    test_protocol_err();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
